// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - shared load encodings, FSM states and legality helper
package mem_load_unit_pkg;

  localparam logic [6:0] OPC_S_TYPE = 7'b0100011;
  localparam logic [6:0] OPC_I_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef struct packed {
    logic [1:0] off;
    logic [2:0] funct3;
    logic [4:0] rd;
  } ld_ctx_t;

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b1;
      F3_LH, F3_LHU: return ~off[0];
      F3_LW:         return (off == 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_load_extend.sv
// rtl/mem_load_unit_load_extend.sv - lane select and sign/zero extension of a DRAM read word
module load_extend
  import mem_load_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'd0, byte_lane};
      F3_LHU:  data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MEM-stage load path: DRAM read handshake, stall, extend and writeback
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int DRAM_AW = 14,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [2:0]         ld_funct3,
  input  logic [31:0]        ld_addr,
  input  logic [4:0]         ld_rd,
  input  logic               flush,
  output logic               stall,
  output logic               ld_done,
  output logic [31:0]        ld_data,
  output logic [4:0]         ld_rd_out,
  output logic               ld_err,
  output logic               dram_rd_req,
  output logic [DRAM_AW-1:0] dram_addr,
  input  logic               dram_gnt,
  input  logic               dram_rvalid,
  input  logic [31:0]        dram_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  ld_ctx_t            ctx_q, ctx_d;
  logic [DRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [4:0]         rd_q, rd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic        legal;
  logic        timeout_hit;
  logic [31:0] ext_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = &{1'b0, ld_addr[31:DRAM_AW+2]};
  assign legal          = load_legal(ld_funct3, ld_addr[1:0]);
  assign timeout_hit    = (cnt_q == CW'(TIMEOUT - 1));

  load_extend u_load_extend (
    .funct3  (ctx_q.funct3),
    .addr_lo (ctx_q.off),
    .rdata   (dram_rdata),
    .data    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_valid && !flush) begin
          if (legal) begin
            ctx_d   = '{off: ld_addr[1:0], funct3: ld_funct3, rd: ld_rd};
            addr_d  = ld_addr[DRAM_AW+1:2];
            state_d = ST_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A granted request must see its read data back, so a flush after gnt drains.
        if (dram_gnt) begin
          cnt_d = '0;
          if (dram_rvalid && flush) begin
            state_d = ST_IDLE;
          end else if (dram_rvalid) begin
            data_d  = ext_data;
            rd_d    = ctx_q.rd;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = flush ? ST_DRAIN : ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dram_rvalid && flush) begin
          state_d = ST_IDLE;
        end else if (dram_rvalid) begin
          data_d  = ext_data;
          rd_d    = ctx_q.rd;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_DRAIN: begin
        if (dram_rvalid || timeout_hit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign stall = ld_valid & ~flush & (state_q != ST_DONE) & ~((state_q == ST_IDLE) & ~legal);
  assign dram_rd_req = (state_q == ST_REQ);
  assign dram_addr   = addr_q;
  assign ld_done     = done_q;
  assign ld_err      = err_q;
  assign ld_data     = data_q;
  assign ld_rd_out   = rd_q;

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- MEM-stage load path of the five-stage RISC-V pipeline.
- Accepts a load from MEM and issues a word read to the data DRAM over a request/grant/valid handshake.
- Stalls the pipeline until read data returns, then aligns and sign/zero-extends the byte/half/word and presents it with its rd to MEM/WB and the forwarding network.
- Read-side counterpart of the store-data forwarding/DRAM-write path.

Parameters:
- DRAM_AW, 14, DRAM word-address width; dram_addr = ld_addr[DRAM_AW+1:2].
- TIMEOUT, 255, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  MEM stage holds a load; held stable while stall high.
- ld_funct3  in  3  0=LB 1=LH 2=LW 4=LBU 5=LHU.
- ld_addr  in  32  byte address (ALU result).
- ld_rd  in  5  destination register.
- flush  in  1  kill in-flight load (branch/exception).
- stall  out  1  freeze IF..MEM.
- ld_done  out  1  one-cycle pulse: ld_data/ld_rd_out valid.
- ld_data  out  32  extended load result; held until next ld_done.
- ld_rd_out  out  5  rd of completed load; held with ld_data.
- ld_err  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
- dram_rd_req  out  1  read request.
- dram_addr  out  DRAM_AW  word address, registered at acceptance.
- dram_gnt  in  1  DRAM accepted request.
- dram_rvalid  in  1  dram_rdata valid.
- dram_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; timeout counter 0; captured addr[1:0]/funct3/rd 0.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Legality check: LH/LHU need addr[0]=0. LW needs addr[1:0]=0. funct3 3/6/7 is illegal.
- IDLE:
  - ld_valid & legal & ~flush: capture addr, funct3, rd; go to REQ.
  - ld_valid & ~legal & ~flush: pulse ld_err next cycle; stay IDLE; no DRAM request.
- REQ:
  - dram_rd_req=1, dram_addr stable.
  - dram_gnt goes to WAIT and clears the counter.
  - flush before gnt goes to IDLE; req drops next cycle.
- WAIT:
  - dram_rvalid: register the extended data, ld_rd_out and ld_done; go to DONE.
  - flush: go to DRAIN.
  - Counter reaches TIMEOUT: pulse ld_err, set ld_data=0, go to IDLE.
- DONE: ld_done=1 for this cycle only; unconditionally go to IDLE. ld_valid in this cycle belongs to the completed load and is ignored.
- DRAIN:
  - Wait for dram_rvalid, discard the data, go to IDLE. No ld_done.
  - New loads are not accepted and stall stays high while ld_valid is asserted.
  - Timeout also applies here: return to IDLE and suppress ld_err.
- stall (combinational) = ld_valid & ~flush & ~(state==DONE) & ~(state==IDLE & ~legal).
- Minimum latency, with gnt on the first REQ cycle and rvalid the cycle after: ld_valid at N, REQ N+1, WAIT N+2, rvalid N+2, ld_done N+3. stall is high N..N+2 and low at N+3.
- rvalid in the same cycle as gnt, while in REQ: accepted; go directly to DONE.
- Extraction from captured addr[1:0]:
  - Byte lane = rdata[8*a+7:8*a]; half lane = rdata[16*a[1]+15:16*a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- ld_rd_out = 0 yields ld_done with no architectural write. Downstream gating is not this block's job.
- rvalid outside WAIT/REQ/DRAIN is ignored.

Decomposition:
- Shared defines header: funct3 load encodings (LB, LH, LW, LBU, LHU) and the FSM state encodings, alongside the existing opcode defines (I-load opcode next to S_type).
- Sub-module: load_extend. Combinational; inputs funct3, addr[1:0], rdata; output 32-bit extended data.

Test Plan:
- LB at addr 0x103, rdata=0x80FF_1234, gnt immediate, rvalid next cycle -> ld_data=0xFFFF_FF80, ld_done at N+3, stall high exactly 3 cycles.
- LHU at addr 0x102, rdata=0x8001_0000, gnt delayed 4 cycles -> ld_data=0x0000_8001, dram_addr=0x40 held through REQ.
- LW at addr 0x2 -> ld_err pulse at N+1, dram_rd_req never asserted, stall low.
- LW, flush one cycle after gnt, rvalid 3 cycles later -> no ld_done, state returns to IDLE after rvalid, stall high while ld_valid is held.
- LW with rvalid never returned, TIMEOUT=8 -> ld_err after 8 WAIT cycles, ld_data=0, next load serviced normally.
- rst_n asserted mid-WAIT -> all outputs 0 immediately, dram_rd_req 0, following LW completes normally.
